// File: rtl/fin_addr_seq.sv
// fin_addr_seq: registered, self-sequencing final-address streamer.
// On an accepted start it snapshots every channel address, the channel
// enable mask and a signed base offset, then presents base+address for each
// enabled channel in ascending order over a valid/ready handshake, and
// finishes with a single-cycle done pulse.
module fin_addr_seq #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int N_CH = 10,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [N_CH-1:0]               ch_mask,
  input  logic [N_CH*ADDRESS_WIDTH-1:0] din,
  input  logic [ADDRESS_WIDTH-1:0]      base_offset,
  output logic [ADDRESS_WIDTH-1:0]      dout,
  output logic [SEL_W-1:0]              dout_sel,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          busy,
  output logic                          done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [N_CH*ADDRESS_WIDTH-1:0] snap_din, snap_din_nxt;
  logic [N_CH-1:0]               snap_mask, snap_mask_nxt;
  logic [ADDRESS_WIDTH-1:0]      snap_base, snap_base_nxt;
  logic [ADDRESS_WIDTH-1:0]      dout_nxt;
  logic [SEL_W-1:0]              sel_nxt;
  logic                          valid_nxt;

  // {found, index} of the lowest enabled channel at or above lo
  logic [SEL_W:0] first_hit;
  logic [SEL_W:0] next_hit;

  // Lowest set bit of m whose position is >= lo; the MSB of the result
  // flags whether any such bit exists.
  function automatic logic [SEL_W:0] find_set(input logic [N_CH-1:0] m,
                                              input int lo);
    logic [SEL_W:0] r;
    r = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (m[i] && (i >= lo)) begin
        r = {1'b1, SEL_W'(i)};
      end
    end
    return r;
  endfunction

  // Pick one channel's address out of the packed vector.
  function automatic logic [ADDRESS_WIDTH-1:0] chan(
      input logic [N_CH*ADDRESS_WIDTH-1:0] v,
      input logic [SEL_W-1:0]              idx);
    logic [ADDRESS_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (SEL_W'(i) == idx) begin
        r = v[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      end
    end
    return r;
  endfunction

  // The first channel comes from the live mask; later ones come from the
  // snapshot, strictly above the channel currently on dout.
  always_comb begin
    first_hit = find_set(ch_mask, 0);
    next_hit  = find_set(snap_mask, int'(dout_sel) + 1);
  end

  // Next-state and next-output logic; everything holds unless a start is
  // accepted in IDLE or a beat is accepted in RUN.
  always_comb begin
    state_nxt     = state;
    snap_din_nxt  = snap_din;
    snap_mask_nxt = snap_mask;
    snap_base_nxt = snap_base;
    dout_nxt      = dout;
    sel_nxt       = dout_sel;
    valid_nxt     = dout_valid;
    case (state)
      IDLE: begin
        if (start) begin
          if (first_hit[SEL_W]) begin
            snap_din_nxt  = din;
            snap_mask_nxt = ch_mask;
            snap_base_nxt = base_offset;
            sel_nxt       = first_hit[SEL_W-1:0];
            dout_nxt      = chan(din, first_hit[SEL_W-1:0]) + base_offset;
            valid_nxt     = 1'b1;
            state_nxt     = RUN;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      RUN: begin
        if (dout_valid && dout_ready) begin
          if (next_hit[SEL_W]) begin
            sel_nxt  = next_hit[SEL_W-1:0];
            dout_nxt = chan(snap_din, next_hit[SEL_W-1:0]) + snap_base;
          end else begin
            valid_nxt = 1'b0;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, snapshot and output registers; reset aborts any sequence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      snap_din   <= '0;
      snap_mask  <= '0;
      snap_base  <= '0;
      dout       <= '0;
      dout_sel   <= '0;
      dout_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      snap_din   <= snap_din_nxt;
      snap_mask  <= snap_mask_nxt;
      snap_base  <= snap_base_nxt;
      dout       <= dout_nxt;
      dout_sel   <= sel_nxt;
      dout_valid <= valid_nxt;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_fin_addr_seq.sv
// Testbench for fin_addr_seq: directed scenarios plus randomized sequences,
// checked by a scoreboard fed from a behavioural model of the stream.
module tb_fin_addr_seq;

  localparam int AW    = 8;
  localparam int N_CH  = 10;
  localparam int SEL_W = $clog2(N_CH);

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [AW-1:0]    val;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 start = 1'b0;
  logic [N_CH-1:0]      ch_mask = '0;
  logic [N_CH*AW-1:0]   din = '0;
  logic [AW-1:0]        base_offset = '0;
  logic [AW-1:0]        dout;
  logic [SEL_W-1:0]     dout_sel;
  logic                 dout_valid;
  logic                 dout_ready = 1'b0;
  logic                 busy;
  logic                 done;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int expDone = 0;
  int doneSeen = 0;
  int doneCyc = 0;
  int beatsSeen = 0;
  int readyMode = 0;
  int holdCnt = 0;
  beat_t expQ[$];
  logic [AW-1:0] lastDout;
  bit prevHold = 1'b0;
  logic [AW-1:0] prevDout;
  logic [SEL_W-1:0] prevSel;

  fin_addr_seq #(.ADDRESS_WIDTH(AW), .N_CH(N_CH)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .ch_mask(ch_mask),
    .din(din),
    .base_offset(base_offset),
    .dout(dout),
    .dout_sel(dout_sel),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .busy(busy),
    .done(done)
  );

  // Free-running clock and cycle counter used for latency measurements.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // Issue one start; the model expands the request into the ordered list of
  // beats (channel, signed sum wrapped to AW bits) and one expected done.
  task automatic applyStimulus(input logic [N_CH-1:0] m,
                               input logic [N_CH*AW-1:0] d,
                               input logic [AW-1:0] b,
                               output int sc);
    logic signed [AW-1:0] sa;
    logic signed [AW-1:0] sb;
    int s;
    beat_t bt;
    @(posedge clk);
    #1;
    start = 1'b1;
    ch_mask = m;
    din = d;
    base_offset = b;
    sc = cyc;
    sb = b;
    for (int i = 0; i < N_CH; i++) begin
      if (m[i]) begin
        sa = d[i*AW +: AW];
        s = int'(sa) + int'(sb);
        bt.sel = SEL_W'(i);
        bt.val = AW'(s);
        expQ.push_back(bt);
      end
    end
    expDone++;
    @(posedge clk);
    #1;
    checkOutput("first_valid", 32'(dout_valid), 32'(m != '0));
    checkOutput("empty_done", 32'(done), 32'(m == '0));
    start = 1'b0;
    ch_mask = N_CH'($urandom);
    base_offset = AW'($urandom);
    for (int i = 0; i < N_CH; i++) din[i*AW +: AW] = AW'($urandom);
  endtask

  task automatic waitDone(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (doneSeen == expDone) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL done_timeout: got %0d done pulses expected %0d",
               doneSeen, expDone);
      expQ.delete();
      expDone = doneSeen;
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
    end
  endtask

  // Ready driver: always ready, random, or two stall cycles per beat.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0: dout_ready = 1'b1;
        1: dout_ready = 1'($urandom_range(0, 1));
        default: begin
          if (dout_valid && holdCnt < 2) begin
            dout_ready = 1'b0;
            holdCnt++;
          end else begin
            dout_ready = 1'b1;
            holdCnt = 0;
          end
        end
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted beat, checks stability
  // under backpressure and that done only follows the last expected beat.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prevHold = 1'b0;
      end else begin
        checkOutput("busy_vs_valid", 32'(busy), 32'(dout_valid));
        if (prevHold && dout_valid) begin
          checkOutput("hold_dout", 32'(dout), 32'(prevDout));
          checkOutput("hold_sel", 32'(dout_sel), 32'(prevSel));
        end
        if (dout_valid && dout_ready) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_beat", 32'(dout_sel), 32'hFFFF_FFFF);
          end else begin
            beat_t e;
            e = expQ.pop_front();
            checkOutput("beat_sel", 32'(dout_sel), 32'(e.sel));
            checkOutput("beat_dout", 32'(dout), 32'(e.val));
          end
          lastDout = dout;
          beatsSeen++;
        end
        if (done) begin
          if (doneSeen >= expDone) begin
            checkOutput("unexpected_done", 32'(done), 32'h0);
          end else begin
            checkOutput("done_after_last_beat", 32'(expQ.size()), 32'h0);
            checkOutput("valid_low_at_done", 32'(dout_valid), 32'h0);
            doneSeen++;
            doneCyc = cyc;
          end
        end
        prevHold = dout_valid && !dout_ready;
        prevDout = dout;
        prevSel = dout_sel;
      end
    end
  end

  initial begin
    int sc;
    int b0;
    logic [N_CH*AW-1:0] d;
    logic [N_CH-1:0] m;

    // Reset then idle
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs", 32'({dout, dout_sel, dout_valid, busy, done}), 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      checkOutput("idle_outputs", 32'({dout, dout_sel, dout_valid, busy, done}), 32'h0);
    end

    // Full sweep, ready tied high
    readyMode = 0;
    for (int i = 0; i < N_CH; i++) d[i*AW +: AW] = AW'(i * 3);
    applyStimulus(10'h3FF, d, 8'd5, sc);
    waitDone(60);
    checkOutput("sweep_done_latency", 32'(doneCyc - sc), 32'd11);
    checkOutput("sweep_busy_after", 32'(busy), 32'h0);
    checkOutput("sweep_last_dout", 32'(lastDout), 32'd32);

    // Sparse mask with two stall cycles per beat
    readyMode = 2;
    for (int i = 0; i < N_CH; i++) d[i*AW +: AW] = AW'(10 + i);
    applyStimulus(10'b1000100100, d, 8'd0, sc);
    waitDone(60);
    checkOutput("sparse_done_latency", 32'(doneCyc - sc), 32'd10);
    checkOutput("sparse_last_dout", 32'(lastDout), 32'd19);

    // Wrap and negative values
    readyMode = 0;
    d = '0;
    d[0*AW +: AW] = 8'd127;
    applyStimulus(10'b1, d, 8'd1, sc);
    waitDone(20);
    checkOutput("wrap_positive", 32'(lastDout), 32'h80);
    d = '0;
    d[1*AW +: AW] = 8'hFD;
    applyStimulus(10'b10, d, 8'h82, sc);
    waitDone(20);
    checkOutput("wrap_negative", 32'(lastDout), 32'h7F);

    // Empty mask
    applyStimulus('0, d, 8'd3, sc);
    waitDone(20);
    checkOutput("empty_done_latency", 32'(doneCyc - sc), 32'd1);

    // Start during RUN is ignored
    b0 = beatsSeen;
    applyStimulus(10'h00F, d, 8'd7, sc);
    start = 1'b1;
    ch_mask = 10'h3FF;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(40);
    checkOutput("ignored_start_beats", 32'(beatsSeen - b0), 32'd4);
    checkOutput("ignored_start_latency", 32'(doneCyc - sc), 32'd5);
    repeat (3) @(posedge clk);
    checkOutput("ignored_start_done_count", 32'(doneSeen), 32'(expDone));

    // Reset on the third beat, then a clean restart
    for (int i = 0; i < N_CH; i++) d[i*AW +: AW] = AW'($urandom);
    b0 = beatsSeen;
    applyStimulus(10'h3FF, d, AW'($urandom), sc);
    for (int i = 0; i < 20; i++) begin
      if (beatsSeen - b0 >= 2) break;
      @(posedge clk);
      #1;
    end
    checkOutput("third_beat_presented", 32'(dout_valid), 32'h1);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_outputs", 32'({dout, dout_sel, dout_valid, busy, done}), 32'h0);
    expQ.delete();
    expDone = doneSeen;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    for (int i = 0; i < N_CH; i++) d[i*AW +: AW] = AW'($urandom);
    applyStimulus(10'b0101010101, d, AW'($urandom), sc);
    waitDone(40);

    // Randomized sequences with random backpressure and ignored starts
    for (int n = 0; n < 40; n++) begin
      readyMode = $urandom_range(0, 2);
      m = ($urandom_range(0, 5) == 0) ? '0 : N_CH'($urandom);
      for (int i = 0; i < N_CH; i++) d[i*AW +: AW] = AW'($urandom);
      applyStimulus(m, d, AW'($urandom), sc);
      if (expQ.size() > 0 && $urandom_range(0, 2) == 0) begin
        start = 1'b1;
        ch_mask = N_CH'($urandom);
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      waitDone(200);
    end

    repeat (3) @(posedge clk);
    checkOutput("final_done_count", 32'(doneSeen), 32'(expDone));
    checkOutput("final_queue_empty", 32'(expQ.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
